// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the regfile_scb register file
//
// Purpose : state enum for the init/run FSM and default geometry.
// Ports   : none (package).
// Config  : REGFILE_BYPASS_EN (used in regfile_scb.sv) compiles in write-through bypass.
package regfile_pkg;
   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_t;
endpackage

// File: rtl/regfile_scb_if.sv
// rtl/regfile_scb_if.sv - decode/writeback bus of the scoreboarded register file
//
// Purpose : groups read, writeback, issue and flush signals of regfile_scb.
// Ports   : master = decode/writeback side, slave = register file.
//           ready, rd_data, rd_busy, pend_cnt flow slave -> master;
//           rd_adr, we, wr_adr, wr_data, iss_valid, iss_adr, flush flow master -> slave.
interface regfile_scb_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int NREGS = RF_NREGS,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic                ready;
   logic [NRD*AW-1:0]   rd_adr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                we;
   logic [AW-1:0]       wr_adr;
   logic [XLEN-1:0]     wr_data;
   logic                iss_valid;
   logic [AW-1:0]       iss_adr;
   logic                flush;
   logic [AW:0]         pend_cnt;

   modport master (
      input  ready, rd_data, rd_busy, pend_cnt,
      output rd_adr, we, wr_adr, wr_data, iss_valid, iss_adr, flush
   );

   modport slave (
      output ready, rd_data, rd_busy, pend_cnt,
      input  rd_adr, we, wr_adr, wr_data, iss_valid, iss_adr, flush
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write bits, their popcount and per-port busy lookup
//
// Purpose : tracks which registers have an in-flight producer.
// Ports   : clk, rst_n (async active-low); en gates all updates (high in RUN);
//           iss_valid/iss_adr set, we/wr_adr clear, flush clears all;
//           rd_adr (packed per port) -> busy (raw, before any bypass); pend_cnt registered popcount.
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_adr,
   input  logic              we,
   input  logic [AW-1:0]     wr_adr,
   input  logic              flush,
   input  logic [NRD*AW-1:0] rd_adr,
   output logic [NRD-1:0]    busy,
   output logic [AW:0]       pend_cnt
);
   logic [NREGS-1:0] pend_q, pend_d;
   logic [AW:0]      pend_cnt_q, pend_cnt_d;

   // Clear before set: a same-cycle issue belongs to a newer producer and must win.
   // Flush overrides both; bit 0 is forced low so x0 is never busy.
   always_comb begin
      pend_d = pend_q;
      if (en) begin
         if (we)        pend_d[wr_adr]  = 1'b0;
         if (iss_valid) pend_d[iss_adr] = 1'b1;
         if (flush)     pend_d          = '0;
      end
      pend_d[0] = 1'b0;
   end

   always_comb begin
      pend_cnt_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NRD; i++) begin
         busy[i] = pend_q[rd_adr[i*AW +: AW]];
      end
   end

   assign pend_cnt = pend_cnt_q;
endmodule

// File: rtl/regfile_scb.sv
// rtl/regfile_scb.sv - multi-read-port register file with init sweep and RAW scoreboard
//
// Purpose : x0-hardwired register array, combinational reads, zeroing sweep after reset,
//           pending bits per register for hazard detection at decode.
// Ports   : clk, rst_n (async active-low); bus = regfile_scb_if.slave.
// Config  : REGFILE_BYPASS_EN defined -> a same-cycle writeback is forwarded to matching
//           read ports and clears their busy flag for that cycle.
module regfile_scb
   import regfile_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int NREGS = RF_NREGS,
   parameter int NRD   = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_scb_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   rf_state_t        state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]  ram_q [NREGS];
   logic             run;
   logic             wr_ok;
   logic             ram_we;
   logic [AW-1:0]    ram_adr;
   logic [XLEN-1:0]  ram_wdata;
   logic [NRD-1:0]   busy_raw;
   logic [AW:0]      pend_cnt;
   logic [XLEN-1:0]  rd_data_a [NRD];
   logic             rd_busy_a [NRD];

   assign run   = (state_q == RF_RUN);
   assign wr_ok = run && bus.we && (bus.wr_adr != '0);

   // Sweep starts at 1: x0 is never stored, reads of it are forced to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == RF_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == AW'(NREGS-1)) state_d = RF_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RF_INIT;
         cnt_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_adr   = bus.wr_adr;
      ram_wdata = bus.wr_data;
      if (!run) begin
         ram_we    = 1'b1;
         ram_adr   = cnt_q;
         ram_wdata = '0;
      end else if (wr_ok) begin
         ram_we    = 1'b1;
      end
   end

   // The array has no reset; the sweep is what clears it.
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[ram_adr] <= ram_wdata;
   end

   regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_scb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (run),
      .iss_valid (bus.iss_valid),
      .iss_adr   (bus.iss_adr),
      .we        (bus.we),
      .wr_adr    (bus.wr_adr),
      .flush     (bus.flush),
      .rd_adr    (bus.rd_adr),
      .busy      (busy_raw),
      .pend_cnt  (pend_cnt)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] adr;
      logic          hit;
      assign adr = bus.rd_adr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign hit = wr_ok && (bus.wr_adr == adr);
`else
      assign hit = 1'b0;
`endif
      assign rd_data_a[i] = (!run || adr == '0) ? '0 :
                            hit                 ? bus.wr_data : ram_q[adr];
      assign rd_busy_a[i] = busy_raw[i] && !hit;
   end

   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         bus.rd_data[i*XLEN +: XLEN] = rd_data_a[i];
         bus.rd_busy[i]              = rd_busy_a[i];
      end
   end

   assign bus.ready    = run;
   assign bus.pend_cnt = pend_cnt;
endmodule

// File: tb/tb_regfile_scb.sv
// tb/tb_regfile_scb.sv - directed self-checking bench for regfile_scb
module tb_regfile_scb;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_scb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

   regfile_scb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int a0, input int a1);
      bus.rd_adr = {5'(a1), 5'(a0)};
      #1;
   endtask

   task automatic idle();
      bus.we        = 1'b0;
      bus.wr_adr    = '0;
      bus.wr_data   = '0;
      bus.iss_valid = 1'b0;
      bus.iss_adr   = '0;
      bus.flush     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      set_rd(0, 0);
      step();
      step();

      // reset state
      set_rd(5, 9);
      check("rst_ready", bus.ready, 0);
      check("rst_pend_cnt", bus.pend_cnt, 0);
      check("rst_busy", bus.rd_busy, 0);
      check("rst_data", bus.rd_data, 0);

      // sweep with junk traffic that must be ignored
      rst_n         = 1'b1;
      bus.we        = 1'b1;
      bus.wr_adr    = 5'd31;
      bus.wr_data   = 32'hFFFF_FFFF;
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd6;
      bus.flush     = 1'b0;
      set_rd(6, 31);
      for (int e = 1; e <= 31; e++) begin
         step();
         check($sformatf("init_ready_e%0d", e), bus.ready, (e == 31) ? 1 : 0);
         if (e < 31) begin
            check($sformatf("init_data_e%0d", e), bus.rd_data, 0);
            check($sformatf("init_busy_e%0d", e), bus.rd_busy, 0);
         end
      end
      idle();
      #1;
      check("post_init_x31", bus.rd_data[63:32], 0);
      check("post_init_x6_busy", bus.rd_busy[0], 0);
      check("post_init_pend_cnt", bus.pend_cnt, 0);
      for (int a = 0; a < 32; a++) begin
         set_rd(a, 31 - a);
         check($sformatf("swept_x%0d", a), bus.rd_data, 0);
      end

      // issue x5, write it one cycle later
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd5;
      set_rd(5, 0);
      step();
      idle();
      #1;
      check("x5_busy_after_issue", bus.rd_busy[0], 1);
      check("x5_pend_cnt_1", bus.pend_cnt, 1);
      bus.we      = 1'b1;
      bus.wr_adr  = 5'd5;
      bus.wr_data = 32'hDEAD_BEEF;
      #1;
      check("x5_busy_write_cycle", bus.rd_busy[0], BYP ? 0 : 1);
      check("x5_data_write_cycle", bus.rd_data[31:0], BYP ? 32'hDEAD_BEEF : 32'h0);
      step();
      idle();
      #1;
      check("x5_data", bus.rd_data[31:0], 32'hDEAD_BEEF);
      check("x5_busy_cleared", bus.rd_busy[0], 0);
      check("x5_pend_cnt_0", bus.pend_cnt, 0);

      // x0 write and issue
      bus.we        = 1'b1;
      bus.wr_adr    = 5'd0;
      bus.wr_data   = 32'h1234;
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd0;
      set_rd(0, 0);
      check("x0_data_same_cycle", bus.rd_data, 0);
      check("x0_busy_same_cycle", bus.rd_busy, 0);
      step();
      idle();
      #1;
      check("x0_data", bus.rd_data, 0);
      check("x0_busy", bus.rd_busy, 0);
      check("x0_pend_cnt", bus.pend_cnt, 0);

      // same-cycle issue+write x7, issue x3, x9, then flush with issue x4 and write x3
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd7;
      bus.we        = 1'b1;
      bus.wr_adr    = 5'd7;
      bus.wr_data   = 32'h77;
      set_rd(7, 9);
      step();
      idle();
      #1;
      check("x7_still_busy", bus.rd_busy[0], 1);
      check("x7_data", bus.rd_data[31:0], 32'h77);
      check("x7_pend_cnt", bus.pend_cnt, 1);
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd3;
      step();
      bus.iss_adr   = 5'd9;
      step();
      idle();
      #1;
      check("three_pend_cnt", bus.pend_cnt, 3);
      check("x9_busy", bus.rd_busy[1], 1);
      bus.flush     = 1'b1;
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd4;
      bus.we        = 1'b1;
      bus.wr_adr    = 5'd3;
      bus.wr_data   = 32'h33;
      step();
      idle();
      set_rd(7, 4);
      check("flush_pend_cnt", bus.pend_cnt, 0);
      check("flush_busy_x7_x4", bus.rd_busy, 0);
      set_rd(3, 9);
      check("flush_x3_written", bus.rd_data[31:0], 32'h33);
      check("flush_busy_x3_x9", bus.rd_busy, 0);

      // write to x10 while port 1 reads it
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd10;
      step();
      idle();
      bus.we      = 1'b1;
      bus.wr_adr  = 5'd10;
      bus.wr_data = 32'h55;
      set_rd(5, 10);
      check("byp_port1_data", bus.rd_data[63:32], BYP ? 32'h55 : 32'h0);
      check("byp_port1_busy", bus.rd_busy[1], BYP ? 0 : 1);
      check("byp_port0_data", bus.rd_data[31:0], 32'hDEAD_BEEF);
      step();
      idle();
      #1;
      check("x10_data", bus.rd_data[63:32], 32'h55);
      check("x10_busy", bus.rd_busy[1], 0);
      check("x10_pend_cnt", bus.pend_cnt, 0);

      // reset mid-run, then mid-sweep at index 12
      bus.iss_valid = 1'b1;
      bus.iss_adr   = 5'd8;
      step();
      idle();
      #1;
      check("x8_pend_cnt", bus.pend_cnt, 1);
      rst_n = 1'b0;
      set_rd(8, 5);
      check("midrun_rst_ready", bus.ready, 0);
      check("midrun_rst_pend_cnt", bus.pend_cnt, 0);
      check("midrun_rst_busy", bus.rd_busy, 0);
      check("midrun_rst_data", bus.rd_data, 0);
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 11; e++) step();
      rst_n = 1'b0;
      #1;
      check("midsweep_rst_ready", bus.ready, 0);
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 31; e++) begin
         step();
         check($sformatf("resweep_ready_e%0d", e), bus.ready, (e == 31) ? 1 : 0);
      end
      set_rd(5, 10);
      check("resweep_x5_x10", bus.rd_data, 0);
      check("resweep_busy", bus.rd_busy, 0);
      check("resweep_pend_cnt", bus.pend_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_scb.md
# regfile_scb

Parametrised multi-read-port integer register file with an integrated scoreboard, successor to the fixed 2R1W 32x32 register file in the RISC-V core. It keeps x0 hard-wired to zero and combinational reads, and adds three things: async reset, a post-reset zeroing sweep, and per-register pending bits. The pending bits let the decode stage detect RAW hazards against in-flight writebacks. It sits between decode (read and issue) and writeback (write and retire).

## Interface
- `XLEN`, 32, data width
- `NREGS`, 32, register count (power of 2, ≥4); `AW = $clog2(NREGS)`
- `NRD`, 2, read port count (1..4)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ready`  out  1  high once the init sweep is done
- `rd_adr`  in  NRD*AW  read addresses, port i at `[i*AW +: AW]`
- `rd_data`  out  NRD*XLEN  read data, combinational
- `rd_busy`  out  NRD  port i's register has a pending write
- `we`  in  1  writeback enable
- `wr_adr`  in  AW  writeback address
- `wr_data`  in  XLEN  writeback data
- `iss_valid`  in  1  instruction issued that will write `iss_adr`
- `iss_adr`  in  AW  destination register of the issued instruction
- `flush`  in  1  clear all pending bits (pipeline flush)
- `pend_cnt`  out  AW+1  number of registers currently pending

## Operation
- FSM states: `INIT` and `RUN`.
  - Reset forces `INIT`, sweep counter to 1, all pending bits to 0.
  - In `INIT`, each cycle writes 0 to `RAM[cnt]` and increments `cnt`. After writing index `NREGS-1` the FSM goes to `RUN`.
  - In `INIT`, `we`, `iss_valid` and `flush` are ignored, `rd_data`=0 and `rd_busy`=0.
- In `RUN`, a write with `we`=1 stores `wr_data` to `RAM[wr_adr]` on the clock edge and clears `pending[wr_adr]`.
- `iss_valid` sets `pending[iss_adr]`.
- Writes or issues to address 0 are ignored. `rd_data` for address 0 is always 0 and `rd_busy` for address 0 is always 0.
- Simultaneous issue and writeback to the same register: pending stays set, because a new producer owns the register.
- `flush` clears all pending bits. If `iss_valid` is high in the same cycle, `flush` wins and no bit is set. The register write still happens.
- A writeback to a register that is not pending is legal: data is written and the pending bit stays 0.
- `rd_busy[i] = pending[rd_adr_i]`, reduced by bypass when `REGFILE_BYPASS_EN` is defined (see Configuration).
- `pend_cnt` is the registered popcount of the pending bits, updated on the same edge as the bits.

## Timing
- Reset values: `ready`=0, `rd_busy`=0, `pend_cnt`=0, `rd_data`=0.
- `ready` rises on the edge that completes the write to `RAM[NREGS-1]`. That is `NREGS-1` rising edges after `rst_n` deasserts (31 for the defaults).
- Read latency is 0 cycles (combinational). Write, pending and `pend_cnt` updates are visible 1 cycle after the edge.
- Reset asserted mid-sweep or mid-run takes effect immediately. The sweep restarts at index 1.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through bypass is compiled in.
  - A read port with `we`=1, `wr_adr`=`rd_adr_i`≠0, in `RUN`, returns `wr_data` in the same cycle.
  - The same port's `rd_busy[i]` is forced to 0 that cycle.
- `REGFILE_BYPASS_EN` undefined: the read returns the old array value and `rd_busy` stays 1 until the cycle after the write.

## Structure
- Package `regfile_pkg` holds:
  - the state enum `rf_state_t` {`RF_INIT`, `RF_RUN`};
  - the defaults `RF_XLEN`=32 and `RF_NREGS`=32.
- Sub-module `regfile_scoreboard` holds the pending bit vector, set/clear/flush priority, the `pend_cnt` register and the per-port busy lookup.
- The top level holds the array, the FSM, the read muxes and the bypass.

## Test plan
- Reset release with defaults: `ready` is low for 30 edges and high after edge 31. Every `rd_adr` reads 0 and `pend_cnt`=0.
- Issue x5, then write x5=0xDEADBEEF one cycle later:
  - `rd_busy` is 1 for x5 until the write edge;
  - the next cycle reads 0xDEADBEEF, `rd_busy`=0 and `pend_cnt` returns 1→0.
- Write x0=0x1234 and issue x0: reads of x0 return 0, `rd_busy`=0 and `pend_cnt` stays 0.
- Same-cycle issue and write of x7, then issue x3 and x9, then `flush` together with an issue of x4:
  - x7 stays pending after the first step;
  - after the flush all pending bits are 0 and `pend_cnt`=0.
- With `REGFILE_BYPASS_EN`, `we`=1, x10=0x55 and port 1 reading x10 in the same cycle: `rd_data` port 1 = 0x55 and `rd_busy[1]`=0. Without the macro, the old value is returned and `rd_busy[1]`=1.
- Assert `rst_n` low at sweep index 12, then release: the sweep restarts and `ready` rises 31 edges after release.
